// File: rtl/sc_et_stream_ctrl.sv
// sc_et_stream_ctrl
// Stochastic-computing stream sequencer. Accepts a group of N W-bit operands,
// derives the stream precision k from the trailing zeros of the OR of all
// operands, then emits 2^k beats of N correlated SC bits. Each bit comes from
// comparing the operand against a bit-reversed (van der Corput) counter.
//
// Build option: define SC_EARLY_TERM_EN to enable early termination
// (k = W - tz). When it is undefined, every stream runs the full 2^W beats
// and no trailing-zero logic is built.
module sc_et_stream_ctrl #(
  parameter int W  = 8,
  parameter int N  = 2,
  parameter int KW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  Bxs [N-1:0],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_bits,
  output logic          out_last,
  output logic [KW-1:0] prec_k,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t        state_r;
  logic [W-1:0]  bx_r [N-1:0];
  // One bit wider than the operands so c = 2^W - 1 with k = W cannot wrap
  // before the final beat is recognised.
  logic [W:0]    cnt_r;
  logic [W:0]    last_cnt_r;

  logic [KW-1:0] k_s;
  logic [W:0]    lim_s;
  logic [W:0]    cnt_nxt_s;
  logic [W-1:0]  rev_nxt_s;
  logic [N-1:0]  bits_nxt_s;
  logic [N-1:0]  bits_init_s;

  // Bit reversal over W bits: turns a binary counter into a van der Corput
  // sequence, so any 2^k-long prefix lands on multiples of 2^(W-k).
  function automatic logic [W-1:0] bit_rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      r[i] = v[W-1-i];
    end
    return r;
  endfunction

`ifdef SC_EARLY_TERM_EN
  logic [W-1:0] or_s;

  // Trailing-zero count; an all-zero word reports W.
  function automatic logic [KW-1:0] trail_zeros(input logic [W-1:0] v);
    logic [KW-1:0] t;
    t = KW'(W);
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) begin
        t = KW'(i);
      end else begin
        t = t;
      end
    end
    return t;
  endfunction

  // OR of all registered operands: its lowest set bit bounds the precision.
  always_comb begin
    or_s = '0;
    for (int j = 0; j < N; j++) begin
      or_s = or_s | bx_r[j];
    end
    k_s = KW'(W) - trail_zeros(or_s);
  end
`else
  // Early termination disabled: every stream uses full precision.
  always_comb begin
    k_s = KW'(W);
  end
`endif

  // Stream-length limit, next counter value and the lane bits for the
  // first beat (r = 0) and for the beat after the current one.
  always_comb begin
    lim_s      = ((W+1)'(1) << k_s) - (W+1)'(1);
    cnt_nxt_s  = cnt_r + (W+1)'(1);
    rev_nxt_s  = bit_rev(cnt_nxt_s[W-1:0]);
    bits_nxt_s  = '0;
    bits_init_s = '0;
    for (int j = 0; j < N; j++) begin
      bits_nxt_s[j]  = (bx_r[j] > rev_nxt_s);
      bits_init_s[j] = (bx_r[j] != {W{1'b0}});
    end
  end

  // Control FSM with registered outputs. The outputs for a beat are
  // produced one edge ahead from the next counter value, so they stay
  // stable for as long as the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_bits   <= '0;
      out_last   <= 1'b0;
      prec_k     <= '0;
      busy       <= 1'b0;
      cnt_r      <= '0;
      last_cnt_r <= '0;
      for (int j = 0; j < N; j++) begin
        bx_r[j] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            for (int j = 0; j < N; j++) begin
              bx_r[j] <= Bxs[j];
            end
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_r  <= ST_LOAD;
          end else begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        ST_LOAD: begin
          prec_k     <= k_s;
          last_cnt_r <= lim_s;
          cnt_r      <= '0;
          out_bits   <= bits_init_s;
          out_last   <= (k_s == KW'(0));
          out_valid  <= 1'b1;
          state_r    <= ST_RUN;
        end
        ST_RUN: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_bits  <= '0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              cnt_r     <= '0;
              state_r   <= ST_IDLE;
            end else begin
              cnt_r    <= cnt_nxt_s;
              out_bits <= bits_nxt_s;
              out_last <= (cnt_nxt_s == last_cnt_r);
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_bits  <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_et_stream_ctrl.sv
// Directed self-checking bench for sc_et_stream_ctrl with W=4, N=2.
// Expected values depend on whether SC_EARLY_TERM_EN is defined.
module tb_sc_et_stream_ctrl;

`ifdef SC_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] Bxs [1:0];
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_bits;
  logic       out_last;
  logic [2:0] prec_k;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] beat_bits [0:31];

  sc_et_stream_ctrl #(.W(4), .N(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Bxs       (Bxs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .out_last  (out_last),
    .prec_k    (prec_k),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Present one group for a single cycle; returns #1 after the handshake edge.
  task automatic send_group(input logic [3:0] b0, input logic [3:0] b1);
    Bxs[0] = b0;
    Bxs[1] = b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Gathers beats until out_last is transferred; no comparisons in here.
  task automatic collect(input int max_cyc, input bit stall_pat,
                         output int beats, output int ones0, output int ones1,
                         output int last_beat, output int hold_err,
                         output bit timeout);
    bit done, stalled, rdy;
    logic [1:0] pb;
    logic pl;
    int cyc;
    beats = 0; ones0 = 0; ones1 = 0; last_beat = 0; hold_err = 0;
    done = 1'b0; stalled = 1'b0; cyc = 0; pb = 2'b00; pl = 1'b0;
    while (!done && cyc < max_cyc) begin
      rdy = stall_pat ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      out_ready = rdy;
      if (out_valid) begin
        if (stalled && (out_bits !== pb || out_last !== pl)) hold_err++;
        if (rdy) begin
          if (beats < 32) beat_bits[beats] = out_bits;
          ones0 += int'(out_bits[0]);
          ones1 += int'(out_bits[1]);
          beats++;
          if (out_last) begin
            last_beat = beats;
            done = 1'b1;
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pb = out_bits;
          pl = out_last;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    timeout = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Bxs[0] = 4'd0; Bxs[1] = 4'd0;
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_bits !== 2'b00) begin n_bad++; $display("FAIL reset_out_bits: got %b want 00", out_bits); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_cmp++; if (prec_k !== 3'd0) begin n_bad++; $display("FAIL reset_prec_k: got %0d want 0", prec_k); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Groups {8,4}: r = 0,8,4,12 on the first four beats in either build.
  task automatic test_basic();
    int beats, o0, o1, lb, he;
    bit to;
    logic [1:0] exp_b [0:3];
    exp_b[0] = 2'b11; exp_b[1] = 2'b00; exp_b[2] = 2'b01; exp_b[3] = 2'b00;
    send_group(4'd8, 4'd4);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_load: got %b want 1", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready_load: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_load: got %b want 0", out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency: got %b want 1", out_valid); end
    n_cmp++; if (prec_k !== (EARLY ? 3'd2 : 3'd4)) begin n_bad++; $display("FAIL basic_prec_k: got %0d want %0d", prec_k, EARLY ? 2 : 4); end
    collect(100, 1'b0, beats, o0, o1, lb, he, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %b want 0", to); end
    n_cmp++; if (beats != (EARLY ? 4 : 16)) begin n_bad++; $display("FAIL basic_beats: got %0d want %0d", beats, EARLY ? 4 : 16); end
    n_cmp++; if (lb != (EARLY ? 4 : 16)) begin n_bad++; $display("FAIL basic_last_beat: got %0d want %0d", lb, EARLY ? 4 : 16); end
    n_cmp++; if (o0 != (EARLY ? 2 : 8)) begin n_bad++; $display("FAIL basic_ones0: got %0d want %0d", o0, EARLY ? 2 : 8); end
    n_cmp++; if (o1 != (EARLY ? 1 : 4)) begin n_bad++; $display("FAIL basic_ones1: got %0d want %0d", o1, EARLY ? 1 : 4); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (beat_bits[i] !== exp_b[i]) begin n_bad++; $display("FAIL basic_beat%0d_bits: got %b want %b", i + 1, beat_bits[i], exp_b[i]); end
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready_after: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_after: got %b want 0", out_valid); end
  endtask

  task automatic test_zero();
    int beats, o0, o1, lb, he;
    bit to;
    send_group(4'd0, 4'd0);
    @(posedge clk); #1;
    n_cmp++; if (out_bits !== 2'b00) begin n_bad++; $display("FAIL zero_bits: got %b want 00", out_bits); end
    n_cmp++; if (out_last !== EARLY) begin n_bad++; $display("FAIL zero_first_last: got %b want %b", out_last, EARLY); end
    n_cmp++; if (prec_k !== (EARLY ? 3'd0 : 3'd4)) begin n_bad++; $display("FAIL zero_prec_k: got %0d want %0d", prec_k, EARLY ? 0 : 4); end
    collect(100, 1'b0, beats, o0, o1, lb, he, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL zero_timeout: got %b want 0", to); end
    n_cmp++; if (beats != (EARLY ? 1 : 16)) begin n_bad++; $display("FAIL zero_beats: got %0d want %0d", beats, EARLY ? 1 : 16); end
    n_cmp++; if (o0 + o1 != 0) begin n_bad++; $display("FAIL zero_ones: got %0d want 0", o0 + o1); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL zero_in_ready_next: got %b want 1", in_ready); end
  endtask

  task automatic test_stall();
    int beats, o0, o1, lb, he;
    bit to;
    send_group(4'd3, 4'd15);
    @(posedge clk); #1;
    n_cmp++; if (prec_k !== 3'd4) begin n_bad++; $display("FAIL stall_prec_k: got %0d want 4", prec_k); end
    collect(200, 1'b1, beats, o0, o1, lb, he, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL stall_timeout: got %b want 0", to); end
    n_cmp++; if (beats != 16) begin n_bad++; $display("FAIL stall_beats: got %0d want 16", beats); end
    n_cmp++; if (lb != 16) begin n_bad++; $display("FAIL stall_last_beat: got %0d want 16", lb); end
    n_cmp++; if (o0 != 3) begin n_bad++; $display("FAIL stall_ones0: got %0d want 3", o0); end
    n_cmp++; if (o1 != 15) begin n_bad++; $display("FAIL stall_ones1: got %0d want 15", o1); end
    n_cmp++; if (he != 0) begin n_bad++; $display("FAIL stall_hold: got %0d changes want 0", he); end
    n_cmp++; if (beat_bits[15] !== 2'b00) begin n_bad++; $display("FAIL stall_r15_bits: got %b want 00", beat_bits[15]); end
  endtask

  task automatic test_back_to_back();
    int beats, o0, o1, lb, he;
    bit to;
    Bxs[0] = 4'd8; Bxs[1] = 4'd4;
    in_valid = 1'b1;
    @(posedge clk); #1;
    Bxs[0] = 4'd1; Bxs[1] = 4'd0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_in_ready_run: got %b want 0", in_ready); end
    collect(100, 1'b0, beats, o0, o1, lb, he, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL b2b_a_timeout: got %b want 0", to); end
    n_cmp++; if (o0 != (EARLY ? 2 : 8)) begin n_bad++; $display("FAIL b2b_a_ones0: got %0d want %0d", o0, EARLY ? 2 : 8); end
    n_cmp++; if (o1 != (EARLY ? 1 : 4)) begin n_bad++; $display("FAIL b2b_a_ones1: got %0d want %0d", o1, EARLY ? 1 : 4); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_gap_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_b_accepted: got %b want 1", busy); end
    @(posedge clk); #1;
    n_cmp++; if (prec_k !== 3'd4) begin n_bad++; $display("FAIL b2b_b_prec_k: got %0d want 4", prec_k); end
    collect(100, 1'b0, beats, o0, o1, lb, he, to);
    n_cmp++; if (beats != 16) begin n_bad++; $display("FAIL b2b_b_beats: got %0d want 16", beats); end
    n_cmp++; if (o0 != 1) begin n_bad++; $display("FAIL b2b_b_ones0: got %0d want 1", o0); end
    n_cmp++; if (o1 != 0) begin n_bad++; $display("FAIL b2b_b_ones1: got %0d want 0", o1); end
  endtask

  task automatic test_reset_mid();
    int beats, o0, o1, lb, he;
    bit to;
    send_group(4'd3, 4'd15);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_valid: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rmid_last: got %b want 0", out_last); end
    n_cmp++; if (prec_k !== 3'd0) begin n_bad++; $display("FAIL rmid_prec_k: got %0d want 0", prec_k); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid_after: got %b want 0", out_valid); end
    send_group(4'd0, 4'd0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_accept: got %b want 1", busy); end
    @(posedge clk); #1;
    collect(100, 1'b0, beats, o0, o1, lb, he, to);
    n_cmp++; if (beats != (EARLY ? 1 : 16)) begin n_bad++; $display("FAIL rmid_beats: got %0d want %0d", beats, EARLY ? 1 : 16); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
